// File: rtl/game_state_ctrl_if.sv
// Bundle of game-controller stimulus inputs and layer/command outputs.
// master drives the game events; slave is the state controller.
interface game_state_ctrl_if;
    logic       one_ms_tick;
    logic       start_tick;
    logic       jump_left_in;
    logic       jump_right_in;
    logic       elapsed;
    logic       landed;
    logic       fell;
    logic       jump_left;
    logic       jump_right;
    logic       time_bar_start;
    logic       start_screen_en;
    logic       blocks_en;
    logic       time_bar_en;
    logic       character_en;
    logic       points_en;
    logic       end_screen_en;
    logic [1:0] state;

    modport master (
        output one_ms_tick, start_tick, jump_left_in, jump_right_in,
               elapsed, landed, fell,
        input  jump_left, jump_right, time_bar_start,
               start_screen_en, blocks_en, time_bar_en, character_en,
               points_en, end_screen_en, state
    );

    modport slave (
        input  one_ms_tick, start_tick, jump_left_in, jump_right_in,
               elapsed, landed, fell,
        output jump_left, jump_right, time_bar_start,
               start_screen_en, blocks_en, time_bar_en, character_en,
               points_en, end_screen_en, state
    );
endinterface

// File: rtl/game_state_ctrl.sv
// Game flow controller: START -> PLAY -> DYING -> END -> START, with jump
// gating, time-bar restart pulses and per-state layer enables.
module game_state_ctrl #(
    parameter int unsigned DEATH_DELAY_MS = 1000,
    parameter int unsigned END_HOLD_MS    = 500
) (
    input logic              clk,
    input logic              rst,
    game_state_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = 16;
    localparam int unsigned EN_W  = 6;

    localparam logic [1:0] ST_START = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_DYING = 2'd2;
    localparam logic [1:0] ST_END   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Enable vector order, MSB first: start/blocks/bar/char/points/end.
    localparam logic [EN_W-1:0] EN_START = 6'b100000;
    localparam logic [EN_W-1:0] EN_GAME  = 6'b011110;
    localparam logic [EN_W-1:0] EN_END   = 6'b000011;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] ms_cnt_q, ms_cnt_d;
    logic             lock_q, lock_d;
    logic             jump_left_q, jump_left_d;
    logic             jump_right_q, jump_right_d;
    logic             tbs_q, tbs_d;
    logic [EN_W-1:0]  en_q, en_d;

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_START;
            ms_cnt_q     <= '0;
            lock_q       <= 1'b0;
            jump_left_q  <= 1'b0;
            jump_right_q <= 1'b0;
            tbs_q        <= 1'b0;
            en_q         <= EN_START;
        end else begin
            state_q      <= state_d;
            ms_cnt_q     <= ms_cnt_d;
            lock_q       <= lock_d;
            jump_left_q  <= jump_left_d;
            jump_right_q <= jump_right_d;
            tbs_q        <= tbs_d;
            en_q         <= en_d;
        end
    end

    // Next state, counter and next-cycle output values.
    always_comb begin
        state_d      = state_q;
        ms_cnt_d     = ms_cnt_q;
        lock_d       = lock_q;
        jump_left_d  = 1'b0;
        jump_right_d = 1'b0;
        tbs_d        = 1'b0;
        en_d         = EN_START;

        case (state_q)
            ST_START: begin
                if (bus.start_tick) begin
                    state_d = ST_PLAY;
                    tbs_d   = 1'b1;
                end
            end
            ST_PLAY: begin
                if (bus.elapsed || bus.fell) begin
                    state_d = ST_DYING;
                    lock_d  = 1'b0;
                end else begin
                    if (bus.landed) begin
                        lock_d = 1'b0;
                        tbs_d  = 1'b1;
                    end
                    // Simultaneous left+right requests cancel each other.
                    if (!lock_q && (bus.jump_left_in ^ bus.jump_right_in)) begin
                        jump_left_d  = bus.jump_left_in;
                        jump_right_d = bus.jump_right_in;
                        lock_d       = 1'b1;
                    end
                end
            end
            ST_DYING: begin
                lock_d = 1'b0;
                if (32'(ms_cnt_q) >= DEATH_DELAY_MS) begin
                    state_d = ST_END;
                end
            end
            ST_END: begin
                lock_d = 1'b0;
                if (bus.start_tick && (32'(ms_cnt_q) >= END_HOLD_MS)) begin
                    state_d = ST_START;
                end
            end
            default: begin
                state_d = ST_START;
                lock_d  = 1'b0;
            end
        endcase

        // Counter restarts on any transition, so a tick on that edge is lost.
        if (state_d != state_q) begin
            ms_cnt_d = '0;
        end else if (bus.one_ms_tick && (ms_cnt_q != CNT_MAX)) begin
            ms_cnt_d = ms_cnt_q + CNT_W'(1);
        end

        case (state_d)
            ST_PLAY, ST_DYING: en_d = EN_GAME;
            ST_END:            en_d = EN_END;
            default:           en_d = EN_START;
        endcase
    end

    assign bus.state           = state_q;
    assign bus.jump_left       = jump_left_q;
    assign bus.jump_right      = jump_right_q;
    assign bus.time_bar_start  = tbs_q;
    assign bus.start_screen_en = en_q[5];
    assign bus.blocks_en       = en_q[4];
    assign bus.time_bar_en     = en_q[3];
    assign bus.character_en    = en_q[2];
    assign bus.points_en       = en_q[1];
    assign bus.end_screen_en   = en_q[0];
endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl: pulse scoreboard plus per-scenario
// state/enable checks.
module tb_game_state_ctrl;
    localparam int EV_JL  = 0;
    localparam int EV_JR  = 1;
    localparam int EV_TBS = 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   exp_q[$];
    int   exp_v;
    logic [2:0] pulses;
    logic [5:0] en_obs;

    game_state_ctrl_if bus();

    game_state_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    assign en_obs = {bus.start_screen_en, bus.blocks_en, bus.time_bar_en,
                     bus.character_en, bus.points_en, bus.end_screen_en};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every output pulse must match the next expected event.
    always @(negedge clk) begin
        pulses = {bus.time_bar_start, bus.jump_right, bus.jump_left};
        for (int k = 0; k < 3; k++) begin
            if (pulses[k]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pulse_unexpected: got event %0d, expected none", k);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (exp_v !== k) begin
                        errors++;
                        $display("FAIL pulse_order: got event %0d, expected %0d", k, exp_v);
                    end
                end
            end
        end
    end

    task automatic cycle(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.one_ms_tick = 1'b1;
            cycle();
            bus.one_ms_tick = 1'b0;
            cycle();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cycle(2);
        checks++;
        if (bus.state !== 2'd0) begin
            errors++; $display("FAIL reset_state: got %0d expected 0", bus.state);
        end
        checks++;
        if (en_obs !== 6'b100000) begin
            errors++; $display("FAIL reset_en: got %b expected 100000", en_obs);
        end
        checks++;
        if ({bus.jump_left, bus.jump_right, bus.time_bar_start} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses: got %b expected 000",
                               {bus.jump_left, bus.jump_right, bus.time_bar_start});
        end
        rst = 1'b1;
        cycle();
    endtask

    task automatic test_start();
        bus.start_tick = 1'b1;
        exp_q.push_back(EV_TBS);
        cycle();
        bus.start_tick = 1'b0;
        checks++;
        if (bus.state !== 2'd1) begin
            errors++; $display("FAIL start_state: got %0d expected 1", bus.state);
        end
        checks++;
        if (bus.time_bar_start !== 1'b1) begin
            errors++; $display("FAIL start_tbs: got %b expected 1", bus.time_bar_start);
        end
        checks++;
        if (en_obs !== 6'b011110) begin
            errors++; $display("FAIL start_en: got %b expected 011110", en_obs);
        end
        cycle();
        checks++;
        if (bus.time_bar_start !== 1'b0) begin
            errors++; $display("FAIL start_tbs_once: got %b expected 0", bus.time_bar_start);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL start_pending: got %0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_jumps();
        bus.jump_left_in = 1'b1;
        exp_q.push_back(EV_JL);
        cycle();
        bus.jump_left_in = 1'b0;
        checks++;
        if (bus.jump_left !== 1'b1) begin
            errors++; $display("FAIL jump_left_fwd: got %b expected 1", bus.jump_left);
        end
        cycle(2);
        bus.jump_right_in = 1'b1;
        cycle();
        bus.jump_right_in = 1'b0;
        checks++;
        if (bus.jump_right !== 1'b0) begin
            errors++; $display("FAIL jump_locked: got %b expected 0", bus.jump_right);
        end
        cycle(2);
        bus.landed = 1'b1;
        exp_q.push_back(EV_TBS);
        cycle();
        bus.landed = 1'b0;
        checks++;
        if (bus.time_bar_start !== 1'b1) begin
            errors++; $display("FAIL landed_tbs: got %b expected 1", bus.time_bar_start);
        end
        cycle();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL jumps_pending: got %0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_both_jumps();
        bus.jump_left_in  = 1'b1;
        bus.jump_right_in = 1'b1;
        cycle();
        bus.jump_left_in  = 1'b0;
        bus.jump_right_in = 1'b0;
        checks++;
        if ({bus.jump_left, bus.jump_right} !== 2'b00) begin
            errors++; $display("FAIL both_dropped: got %b expected 00",
                               {bus.jump_left, bus.jump_right});
        end
        cycle();
        bus.jump_right_in = 1'b1;
        exp_q.push_back(EV_JR);
        cycle();
        bus.jump_right_in = 1'b0;
        checks++;
        if (bus.jump_right !== 1'b1) begin
            errors++; $display("FAIL after_both_fwd: got %b expected 1", bus.jump_right);
        end
        bus.landed = 1'b1;
        exp_q.push_back(EV_TBS);
        cycle();
        bus.landed = 1'b0;
        cycle();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL both_pending: got %0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_dying();
        bus.elapsed = 1'b1;
        bus.landed  = 1'b1;
        cycle();
        bus.elapsed = 1'b0;
        bus.landed  = 1'b0;
        checks++;
        if (bus.state !== 2'd2) begin
            errors++; $display("FAIL dying_state: got %0d expected 2", bus.state);
        end
        checks++;
        if (bus.time_bar_start !== 1'b0) begin
            errors++; $display("FAIL dying_no_tbs: got %b expected 0", bus.time_bar_start);
        end
        checks++;
        if (en_obs !== 6'b011110) begin
            errors++; $display("FAIL dying_en: got %b expected 011110", en_obs);
        end
        bus.start_tick   = 1'b1;
        bus.jump_left_in = 1'b1;
        cycle();
        bus.start_tick   = 1'b0;
        bus.jump_left_in = 1'b0;
        checks++;
        if (bus.state !== 2'd2 || bus.jump_left !== 1'b0) begin
            errors++; $display("FAIL dying_ignore: got state %0d jl %b expected 2 0",
                               bus.state, bus.jump_left);
        end
        ticks(999);
        checks++;
        if (bus.state !== 2'd2) begin
            errors++; $display("FAIL dying_999: got %0d expected 2", bus.state);
        end
        bus.one_ms_tick = 1'b1;
        cycle();
        bus.one_ms_tick = 1'b0;
        checks++;
        if (bus.state !== 2'd2) begin
            errors++; $display("FAIL dying_1000_edge: got %0d expected 2", bus.state);
        end
        cycle();
        checks++;
        if (bus.state !== 2'd3) begin
            errors++; $display("FAIL end_state: got %0d expected 3", bus.state);
        end
        checks++;
        if (en_obs !== 6'b000011) begin
            errors++; $display("FAIL end_en: got %b expected 000011", en_obs);
        end
    endtask

    task automatic test_end();
        ticks(499);
        bus.start_tick = 1'b1;
        cycle();
        bus.start_tick = 1'b0;
        checks++;
        if (bus.state !== 2'd3) begin
            errors++; $display("FAIL end_hold_499: got %0d expected 3", bus.state);
        end
        ticks(1);
        bus.start_tick = 1'b1;
        cycle();
        bus.start_tick = 1'b0;
        checks++;
        if (bus.state !== 2'd0) begin
            errors++; $display("FAIL end_hold_500: got %0d expected 0", bus.state);
        end
        checks++;
        if (en_obs !== 6'b100000) begin
            errors++; $display("FAIL restart_en: got %b expected 100000", en_obs);
        end
        cycle(2);
        checks++;
        if (bus.state !== 2'd0) begin
            errors++; $display("FAIL single_step: got %0d expected 0", bus.state);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL end_pending: got %0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bus.start_tick = 1'b1;
        exp_q.push_back(EV_TBS);
        cycle();
        bus.start_tick   = 1'b0;
        bus.jump_left_in = 1'b1;
        bus.fell         = 1'b1;
        cycle();
        bus.jump_left_in = 1'b0;
        bus.fell         = 1'b0;
        checks++;
        if (bus.state !== 2'd2 || bus.jump_left !== 1'b0) begin
            errors++; $display("FAIL fell_priority: got state %0d jl %b expected 2 0",
                               bus.state, bus.jump_left);
        end
        ticks(600);
        rst             = 1'b0;
        bus.start_tick  = 1'b1;
        bus.one_ms_tick = 1'b1;
        cycle();
        rst             = 1'b1;
        bus.start_tick  = 1'b0;
        bus.one_ms_tick = 1'b0;
        checks++;
        if (bus.state !== 2'd0 || en_obs !== 6'b100000) begin
            errors++; $display("FAIL reset_dying: got state %0d en %b expected 0 100000",
                               bus.state, en_obs);
        end
        checks++;
        if ({bus.jump_left, bus.jump_right, bus.time_bar_start} !== 3'b000) begin
            errors++; $display("FAIL reset_dying_pulses: got %b expected 000",
                               {bus.jump_left, bus.jump_right, bus.time_bar_start});
        end
        bus.start_tick = 1'b1;
        exp_q.push_back(EV_TBS);
        cycle();
        bus.start_tick   = 1'b0;
        rst              = 1'b0;
        bus.jump_left_in = 1'b1;
        bus.landed       = 1'b1;
        cycle();
        rst              = 1'b1;
        bus.jump_left_in = 1'b0;
        bus.landed       = 1'b0;
        checks++;
        if (bus.state !== 2'd0 ||
            {bus.jump_left, bus.jump_right, bus.time_bar_start} !== 3'b000) begin
            errors++; $display("FAIL reset_play: got state %0d pulses %b expected 0 000",
                               bus.state, {bus.jump_left, bus.jump_right, bus.time_bar_start});
        end
        cycle(2);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL reset_pending: got %0d expected 0", exp_q.size());
        end
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        rst               = 1'b0;
        bus.one_ms_tick   = 1'b0;
        bus.start_tick    = 1'b0;
        bus.jump_left_in  = 1'b0;
        bus.jump_right_in = 1'b0;
        bus.elapsed       = 1'b0;
        bus.landed        = 1'b0;
        bus.fell          = 1'b0;
        cycle();
        test_reset();
        test_start();
        test_jumps();
        test_both_jumps();
        test_dying();
        test_end();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
